// File: rtl/hwag_pkg.sv
// Shared types for the angle/time-base hardware blocks.
package hwag_pkg;

  // Output-compare pulse generator sequencing.
  typedef enum logic [1:0] {
    CPG_IDLE     = 2'd0,
    CPG_WAIT_SET = 2'd1,
    CPG_PULSE    = 2'd2
  } cpg_state_t;

endpackage : hwag_pkg

// File: rtl/compare_eq_reg.sv
// Registered equality comparator: raises hit for one cycle after the
// timebase equals the compare value on an enabled tick.
module compare_eq_reg #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             flush,
  input  logic [WIDTH-1:0] tb,
  input  logic [WIDTH-1:0] val,
  output logic             hit
);

  // Capture the match; flush drops a hit computed against stale compare
  // values (the cycle the working registers are reloaded or the run aborts).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit <= 1'b0;
    end else begin
      hit <= ~flush & ena & (tb == val);
    end
  end

endmodule : compare_eq_reg

// File: rtl/d_ff_wide.sv
// Generic wide register with load enable and asynchronous active-low clear.
module d_ff_wide #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Hold the stored word until a load strobe arrives.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: clocked state always uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : d_ff_wide

// File: rtl/compare_pulse_gen.sv
// Output-compare pulse generator. Drives one actuator pin with a single pulse
// per arm: the pin goes active one cycle after the registered set match and
// inactive one cycle after the registered clear match. Set/clear values are
// staged in a shadow register so the next pulse can be prepared while the
// current one is still running.
module compare_pulse_gen
  import hwag_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] tb,
  input  logic [WIDTH-1:0] set_val,
  input  logic [WIDTH-1:0] clr_val,
  input  logic             load,
  input  logic             arm,
  input  logic             abort,
  input  logic             pol,
  output logic             q,
  output logic             busy,
  output logic             done
);

  cpg_state_t         state;
  logic               active;
  logic [2*WIDTH-1:0] shadow_q;
  logic [2*WIDTH-1:0] work_d;
  logic [2*WIDTH-1:0] work_q;
  logic [WIDTH-1:0]   set_w;
  logic [WIDTH-1:0]   clr_w;
  logic               arm_ok;
  logic               flush;
  logic               hit_set;
  logic               hit_clr;
  logic               same_val;

  // Arm is honoured only from IDLE and only when no abort competes with it.
  assign arm_ok = arm & ~abort & (state == CPG_IDLE);
  assign flush  = arm_ok | abort;

  // Shadow pair: written on every load strobe, never touches a running pulse.
  d_ff_wide #(.W(2*WIDTH)) u_shadow (
    .clk (clk),
    .rst (rst),
    .en  (load),
    .d   ({set_val, clr_val}),
    .q   (shadow_q)
  );

  // Working pair source: a load in the arm cycle bypasses the shadow.
  always_comb begin
    // NOTE: assign a default before any condition so no path leaves the
    // signal unassigned; otherwise synthesis infers a latch.
    work_d = shadow_q;
    if (load) begin
      work_d = {set_val, clr_val};
    end
  end

  // Working pair: frozen for the whole pulse, reloaded only on an accepted arm.
  d_ff_wide #(.W(2*WIDTH)) u_work (
    .clk (clk),
    .rst (rst),
    .en  (arm_ok),
    .d   (work_d),
    .q   (work_q)
  );

  assign set_w    = work_q[2*WIDTH-1:WIDTH];
  assign clr_w    = work_q[WIDTH-1:0];
  assign same_val = (set_w == clr_w);

  compare_eq_reg #(.WIDTH(WIDTH)) u_cmp_set (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .flush (flush),
    .tb    (tb),
    .val   (set_w),
    .hit   (hit_set)
  );

  compare_eq_reg #(.WIDTH(WIDTH)) u_cmp_clr (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .flush (flush),
    .tb    (tb),
    .val   (clr_w),
    .hit   (hit_clr)
  );

  // Pulse sequencer with registered active, busy and done outputs.
  // Hits already carry the ena qualification, so with ena low nothing moves.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= CPG_IDLE;
      active <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state  <= CPG_IDLE;
        active <= 1'b0;
        busy   <= 1'b0;
      end else begin
        unique case (state)
          CPG_IDLE: begin
            if (arm_ok) begin
              state <= CPG_WAIT_SET;
              busy  <= 1'b1;
            end
          end
          CPG_WAIT_SET: begin
            if (hit_set) begin
              if (same_val) begin
                // Zero-length pulse: complete without ever driving the pin.
                state <= CPG_IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state  <= CPG_PULSE;
                active <= 1'b1;
              end
            end
          end
          CPG_PULSE: begin
            if (hit_clr) begin
              state  <= CPG_IDLE;
              active <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
            end
          end
          default: begin
            state  <= CPG_IDLE;
            active <= 1'b0;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

  // Polarity is applied after the flop so a pol change reaches the pin at once.
  assign q = pol ? active : ~active;

endmodule : compare_pulse_gen

// File: tb/tb_compare_pulse_gen.sv
// Directed bench for compare_pulse_gen (8-bit timebase).
module tb_compare_pulse_gen;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] tb_val;
  logic [7:0] set_val;
  logic [7:0] clr_val;
  logic       load;
  logic       arm;
  logic       abort;
  logic       pol;
  logic       q;
  logic       busy;
  logic       done;

  int tests_run = 0;
  int failed    = 0;

  compare_pulse_gen #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .tb      (tb_val),
    .set_val (set_val),
    .clr_val (clr_val),
    .load    (load),
    .arm     (arm),
    .abort   (abort),
    .pol     (pol),
    .q       (q),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] s, input logic [7:0] c);
    ena = 1'b0; load = 1'b1; set_val = s; clr_val = c;
    tick();
    load = 1'b0;
  endtask

  task automatic do_arm(input string tag, input logic exp_busy);
    ena = 1'b0; arm = 1'b1;
    tick();
    arm = 1'b0;
    check({tag, " busy after arm"}, busy, exp_busy);
  endtask

  // Walk the timebase from t0 for n ticks, checking pin/busy/done after each
  // edge against hand-derived index windows. Optional one-cycle abort, load
  // or arm at given indices, and an ena-low window.
  task automatic run_seq(input string name, input int t0, input int n,
                         input int q_first, input int q_last, input int done_i,
                         input int busy_last,
                         input int abort_i = -1,
                         input int ena_lo = -1, input int ena_hi = -1,
                         input int load_i = -1, input int arm_i = -1,
                         input logic [7:0] ld_s = 8'd0, input logic [7:0] ld_c = 8'd0);
    for (int i = 0; i < n; i++) begin
      tb_val = 8'(t0 + i);
      ena    = !(i >= ena_lo && i <= ena_hi);
      abort  = (i == abort_i);
      load   = (i == load_i);
      arm    = (i == arm_i);
      if (i == load_i) begin
        set_val = ld_s;
        clr_val = ld_c;
      end
      tick();
      abort = 1'b0; load = 1'b0; arm = 1'b0;
      check($sformatf("%s i=%0d tb=%0d q", name, i, tb_val), q, (i >= q_first && i <= q_last));
      check($sformatf("%s i=%0d tb=%0d busy", name, i, tb_val), busy, (i <= busy_last));
      check($sformatf("%s i=%0d tb=%0d done", name, i, tb_val), done, (i == done_i));
      if (i == q_first && q_first <= q_last) begin
        pol = 1'b0;
        #1;
        check($sformatf("%s pol=0 inverts active pin", name), q, 1'b0);
        pol = 1'b1;
        #1;
      end
    end
  endtask

  initial begin
    rst = 1'b0; ena = 1'b0; tb_val = '0; set_val = '0; clr_val = '0;
    load = 1'b0; arm = 1'b0; abort = 1'b0; pol = 1'b1;

    // 1. Reset state and combinational polarity.
    #2;
    check("reset q pol=1", q, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    pol = 1'b0;
    #1;
    check("reset q pol=0", q, 1'b1);
    pol = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    check("idle busy after reset release", busy, 1'b0);

    // 2. Basic pulse 10..20: pin active for tb 11..20, done at tb 21.
    do_load(8'd10, 8'd20);
    do_arm("basic", 1'b1);
    run_seq("basic", 0, 31, 11, 20, 21, 20);

    // 3. Wrap 250..5: pin active for tb 251..255,0..5, done at tb 6.
    do_load(8'd250, 8'd5);
    do_arm("wrap", 1'b1);
    run_seq("wrap", 240, 26, 11, 21, 22, 21);

    // 4a. Pulse 30..35; load 40/50 at tb 32 and arm at tb 34 must not disturb it.
    do_load(8'd30, 8'd35);
    do_arm("shadow1", 1'b1);
    run_seq("shadow1", 25, 16, 6, 10, 11, 10, -1, -1, -1, 7, 9, 8'd40, 8'd50);
    // 4b. Arm after done uses the shadowed 40/50.
    do_arm("shadow2", 1'b1);
    run_seq("shadow2", 38, 18, 3, 12, 13, 12);
    // 4c. Load and arm together: 60/70 bypasses the shadow.
    ena = 1'b0; load = 1'b1; arm = 1'b1; set_val = 8'd60; clr_val = 8'd70;
    tick();
    load = 1'b0; arm = 1'b0;
    check("load+arm busy", busy, 1'b1);
    run_seq("loadarm", 58, 18, 3, 12, 13, 12);

    // 5a. Abort at tb 15 during pulse 10..20: pin drops next edge, no done.
    do_load(8'd10, 8'd20);
    do_arm("abort1", 1'b1);
    run_seq("abort1", 5, 21, 6, 9, -1, 9, 10);
    // 5b. Abort in the same cycle as the clear match: no done.
    do_arm("abort2", 1'b1);
    run_seq("abort2", 5, 21, 6, 15, -1, 15, 16);
    // 5c. Abort and arm together in IDLE: arm discarded.
    ena = 1'b0; abort = 1'b1; arm = 1'b1;
    tick();
    abort = 1'b0; arm = 1'b0;
    check("abort+arm busy", busy, 1'b0);
    tick();
    check("abort+arm busy later", busy, 1'b0);

    // 6a. set==clr==12: done after tb 12's match, pin never active.
    do_load(8'd12, 8'd12);
    do_arm("equal", 1'b1);
    run_seq("equal", 5, 12, 1, 0, 8, 7);
    // 6b. ena low during tb 8..9: pulse still 10..20.
    do_load(8'd10, 8'd20);
    do_arm("enahold", 1'b1);
    run_seq("enahold", 5, 21, 6, 15, 16, 15, -1, 3, 4);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule : tb_compare_pulse_gen
